// File: rtl/pixel_stream_pkg.sv
// Shared types and the colour-bar lookup for the pixel stream reader.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        TP_OFF   = 2'd0,
        TP_SOLID = 2'd1,
        TP_BARS  = 2'd2,
        TP_RAMP  = 2'd3
    } tp_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLAIM,
        ST_STREAM,
        ST_RELEASE,
        ST_TP
    } state_t;

    localparam int MAX_PIX_W = 256;

    // {red, green, blue} on/off for bars ordered white..black
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

    function automatic logic chan_on(input logic [2:0] rgb, input int chan);
        logic on;
        case (chan)
            0:       on = rgb[2];
            1:       on = rgb[1];
            2:       on = rgb[0];
            default: on = 1'b0;
        endcase
        return on;
    endfunction

    // Right-aligned pixel, channel 0 in the MSBs; channels beyond blue stay dark.
    function automatic logic [MAX_PIX_W-1:0] bar_color(input logic [2:0] idx,
                                                        input int chan_width,
                                                        input int num_chan);
        logic [MAX_PIX_W-1:0] res;
        logic [MAX_PIX_W-1:0] mask;
        logic [2:0]           rgb;
        rgb  = bar_rgb(idx);
        res  = '0;
        mask = (MAX_PIX_W'(1) << chan_width) - MAX_PIX_W'(1);
        for (int c = 0; c < num_chan; c++) begin
            res = res << chan_width;
            if (chan_on(rgb, c)) begin
                res = res | mask;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pixel_tp_gen.sv
// Combinational test-pattern pixel for a given column: solid, colour bars or ramp.
module pixel_tp_gen
    import pixel_stream_pkg::*;
#(
    parameter int CHAN_WIDTH = 8,
    parameter int NUM_CHAN   = 3,
    parameter int H_ACTIVE   = 480,
    parameter int COL_W      = 9,
    localparam int PIX_W     = NUM_CHAN * CHAN_WIDTH
) (
    input  tp_mode_t               i_mode,
    input  logic [COL_W-1:0]       i_col,
    input  logic [PIX_W-1:0]       i_color,
    output logic [PIX_W-1:0]       o_pixel
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]            w_bar_idx;
    logic [PIX_W-1:0]      w_bar_pix;
    logic [CHAN_WIDTH-1:0] w_ramp;
    logic [PIX_W-1:0]      w_ramp_pix;

    assign w_bar_idx = 3'(i_col / COL_W'(BAR_W));
    assign w_bar_pix = PIX_W'(bar_color(w_bar_idx, CHAN_WIDTH, NUM_CHAN));
    assign w_ramp    = CHAN_WIDTH'(i_col);

    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_ramp
            assign w_ramp_pix[gi*CHAN_WIDTH +: CHAN_WIDTH] = w_ramp;
        end
    endgenerate

    always_comb begin
        o_pixel = '0;
        case (i_mode)
            TP_SOLID: o_pixel = i_color;
            TP_BARS:  o_pixel = w_bar_pix;
            TP_RAMP:  o_pixel = w_ramp_pix;
            default:  o_pixel = '0;
        endcase
    end

endmodule

// File: rtl/pixel_stream_reader.sv
// Claims ping-pong FIFO blocks and streams them as pixels on a registered valid/ready port.
// Test-pattern source is built only when PIXEL_STREAM_READER_TP_EN is defined.
module pixel_stream_reader
    import pixel_stream_pkg::*;
#(
    parameter int CHAN_WIDTH = 8,
    parameter int NUM_CHAN   = 3,
    parameter int SIZE_WIDTH = 24,
    parameter int H_ACTIVE   = 480,
    localparam int PIX_W     = NUM_CHAN * CHAN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read_rdy,
    output logic                  o_read_act,
    input  logic [SIZE_WIDTH-1:0] i_read_size,
    input  logic [PIX_W-1:0]      i_read_data,
    output logic                  o_read_stb,
    input  logic [1:0]            i_tp_mode,
    input  logic [PIX_W-1:0]      i_tp_color,
    output logic [PIX_W-1:0]      o_pixel_data,
    output logic                  o_pixel_valid,
    input  logic                  i_pixel_ready,
    output logic                  o_pixel_last
);

    state_t                r_state, w_state_next;
    logic                  r_read_act;
    logic [SIZE_WIDTH-1:0] r_cnt;
    logic [SIZE_WIDTH-1:0] r_size;
    logic [PIX_W-1:0]      r_pix_data;
    logic                  r_pix_valid;
    logic                  r_pix_last;

    logic                  w_load;
    logic                  w_room;
    logic                  w_pop;
    logic                  w_pop_last;
    logic                  w_tp_req;
    logic                  w_tp_load;
    logic                  w_tp_exit;
    logic                  w_tp_last;
    logic [PIX_W-1:0]      w_tp_pixel;

    assign w_load     = !r_pix_valid || i_pixel_ready;
    assign w_room     = r_cnt < r_size;
    // Pop is combinational so the FIFO advances on the same edge that captures its word.
    assign w_pop      = (r_state == ST_STREAM) && w_load && w_room && !rst;
    assign w_pop_last = (r_cnt + SIZE_WIDTH'(1)) == r_size;

`ifdef PIXEL_STREAM_READER_TP_EN
    localparam int              COL_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);

    tp_mode_t         r_tp_mode;
    logic [COL_W-1:0] r_col;

    assign w_tp_req  = i_tp_mode != 2'd0;
    assign w_tp_last = r_col == COL_LAST;
    assign w_tp_exit = (r_state == ST_TP) && r_pix_valid && i_pixel_ready &&
                       r_pix_last && !w_tp_req;
    assign w_tp_load = (r_state == ST_TP) && w_load && !w_tp_exit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tp_mode <= TP_OFF;
            r_col     <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_tp_mode <= tp_mode_t'(i_tp_mode);
            end
            if (w_tp_load) begin
                r_col <= w_tp_last ? '0 : r_col + COL_W'(1);
            end
        end
    end

    pixel_tp_gen #(
        .CHAN_WIDTH (CHAN_WIDTH),
        .NUM_CHAN   (NUM_CHAN),
        .H_ACTIVE   (H_ACTIVE),
        .COL_W      (COL_W)
    ) u_tp_gen (
        .i_mode  (r_tp_mode),
        .i_col   (r_col),
        .i_color (i_tp_color),
        .o_pixel (w_tp_pixel)
    );
`else
    logic w_unused_tp;
    assign w_unused_tp = ^{i_tp_mode, i_tp_color};
    assign w_tp_req    = 1'b0;
    assign w_tp_last   = 1'b0;
    assign w_tp_exit   = 1'b0;
    assign w_tp_load   = 1'b0;
    assign w_tp_pixel  = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_tp_req) begin
                    w_state_next = ST_TP;
                end else if (i_read_rdy) begin
                    w_state_next = ST_CLAIM;
                end
            end
            ST_CLAIM:   w_state_next = ST_STREAM;
            ST_STREAM: begin
                if (!w_room || (w_pop && w_pop_last)) begin
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: w_state_next = ST_IDLE;
            ST_TP: begin
                if (w_tp_exit) begin
                    w_state_next = ST_IDLE;
                end
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_read_act  <= 1'b0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_pix_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == ST_IDLE) && (w_state_next == ST_CLAIM)) begin
                r_read_act <= 1'b1;
                r_cnt      <= '0;
            end else if (r_state == ST_RELEASE) begin
                r_read_act <= 1'b0;
            end
            if (r_state == ST_CLAIM) begin
                r_size <= i_read_size;
            end
            // A held final pixel drains here independently of the FSM.
            if (w_pop) begin
                r_cnt       <= r_cnt + SIZE_WIDTH'(1);
                r_pix_data  <= i_read_data;
                r_pix_valid <= 1'b1;
                r_pix_last  <= w_pop_last;
            end else if (w_tp_load) begin
                r_pix_data  <= w_tp_pixel;
                r_pix_valid <= 1'b1;
                r_pix_last  <= w_tp_last;
            end else if (i_pixel_ready) begin
                r_pix_valid <= 1'b0;
                r_pix_last  <= 1'b0;
            end
        end
    end

    assign o_read_act    = r_read_act;
    assign o_read_stb    = w_pop;
    assign o_pixel_data  = r_pix_data;
    assign o_pixel_valid = r_pix_valid;
    assign o_pixel_last  = r_pix_last;

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Scoreboard bench: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_pixel_stream_reader;

    localparam int CW = 8;
    localparam int NC = 3;
    localparam int SW = 24;
    localparam int HA = 16;
    localparam int PW = CW * NC;

    localparam logic [PW-1:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read_rdy = 1'b0;
    logic          o_read_act;
    logic [SW-1:0] i_read_size = '0;
    logic [PW-1:0] i_read_data = '0;
    logic          o_read_stb;
    logic [1:0]    i_tp_mode = 2'd0;
    logic [PW-1:0] i_tp_color = '0;
    logic [PW-1:0] o_pixel_data;
    logic          o_pixel_valid;
    logic          i_pixel_ready = 1'b0;
    logic          o_pixel_last;

    always #5 clk = ~clk;

    pixel_stream_reader #(
        .CHAN_WIDTH (CW),
        .NUM_CHAN   (NC),
        .SIZE_WIDTH (SW),
        .H_ACTIVE   (HA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_read_rdy    (i_read_rdy),
        .o_read_act    (o_read_act),
        .i_read_size   (i_read_size),
        .i_read_data   (i_read_data),
        .o_read_stb    (o_read_stb),
        .i_tp_mode     (i_tp_mode),
        .i_tp_color    (i_tp_color),
        .o_pixel_data  (o_pixel_data),
        .o_pixel_valid (o_pixel_valid),
        .i_pixel_ready (i_pixel_ready),
        .o_pixel_last  (o_pixel_last)
    );

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    int            n_tests  = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            pop_cnt  = 0;
    int            rdy_mode = 0;
    logic [PW-1:0] blk [64];
    int            blk_size = 0;
    int            ptr      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sink ready: 0 = always, 1 = toggle, 2 = random, 3 = stalled
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       i_pixel_ready = 1'b1;
            1:       i_pixel_ready = ~i_pixel_ready;
            2:       i_pixel_ready = 1'($urandom_range(0, 1));
            default: i_pixel_ready = 1'b0;
        endcase
    end

    // First-word-fall-through FIFO: the word advances after an edge that saw a pop.
    initial begin
        logic s;
        forever begin
            @(negedge clk);
            s = o_read_stb;
            @(posedge clk);
            #1;
            if (s) ptr++;
            i_read_data = (ptr < blk_size) ? blk[ptr] : PW'($urandom);
        end
    end

    initial begin
        logic          hold;
        logic [PW-1:0] hd;
        logic          hl;
        exp_t          e;
        hold = 1'b0;
        hd   = '0;
        hl   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (o_read_stb) begin
                    pop_cnt++;
                    n_tests++;
                    if (!o_read_act || (o_pixel_valid && !i_pixel_ready)) begin
                        n_fail++;
                        $display("FAIL stb_gate: act=%b valid=%b ready=%b, required act=1 and no stall",
                                 o_read_act, o_pixel_valid, i_pixel_ready);
                    end
                end
                if (hold) begin
                    n_tests++;
                    if (!o_pixel_valid || o_pixel_data != hd || o_pixel_last != hl) begin
                        n_fail++;
                        $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                                 o_pixel_valid, o_pixel_data, o_pixel_last, hd, hl);
                    end
                end
                if (o_pixel_valid && i_pixel_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pixel: data=%h last=%b, required no pixel",
                                 o_pixel_data, o_pixel_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_pixel_data != e.data || o_pixel_last != e.last) begin
                            n_fail++;
                            $display("FAIL pixel: data=%h last=%b, required data=%h last=%b",
                                     o_pixel_data, o_pixel_last, e.data, e.last);
                        end else begin
                            $display("[TB] pixel %h last=%b ok", o_pixel_data, o_pixel_last);
                        end
                    end
                end
                hold = o_pixel_valid && !i_pixel_ready;
                hd   = o_pixel_data;
                hl   = o_pixel_last;
            end
        end
    end

    task automatic check_eq(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic start_block(input int size, input bit seq);
        @(posedge clk);
        #1;
        blk_size = size;
        for (int i = 0; i < size; i++) begin
            blk[i] = seq ? PW'(24'h112233 + i * 24'h111111) : PW'($urandom);
            exp_q.push_back('{data: blk[i], last: (i == size - 1)});
        end
        ptr         = 0;
        i_read_data = (size > 0) ? blk[0] : '0;
        i_read_size = SW'(size);
        i_read_rdy  = 1'b1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_q_le(input int n);
        for (int k = 0; k < 1000 && exp_q.size() > n; k++) @(negedge clk);
        n_tests++;
        if (exp_q.size() > n) begin
            n_fail++;
            $display("FAIL queue_wait: got %0d entries, required <= %0d", exp_q.size(), n);
        end
    endtask

    // Edge indices: the pop for an stb seen after edge n lands on edge n+1.
    task automatic finish_block(input int size, input bit chk_timing);
        int c0, act_e, first_s, last_s, fall_e, act_n, pops, vld_n;
        c0 = cyc; act_e = -1; first_s = -1; last_s = -1; fall_e = -1;
        act_n = 0; pops = 0; vld_n = 0;
        for (int k = 0; k < 600 && fall_e < 0; k++) begin
            @(negedge clk);
            if (o_read_act) begin
                act_n++;
                i_read_rdy = 1'b0;
                if (act_e < 0) act_e = cyc;
            end else if (act_e >= 0) begin
                fall_e = cyc;
            end
            if (o_read_stb) begin
                pops++;
                if (first_s < 0) first_s = cyc;
                last_s = cyc;
            end
            if (o_pixel_valid) vld_n++;
        end
        check_eq("release_seen", (fall_e >= 0) ? 1 : 0, 1);
        check_eq("pop_count", pops, size);
        $display("[TB] block size=%0d pops=%0d act_cycles=%0d", size, pops, act_n);
        if (chk_timing) begin
            check_eq("rdy_to_act", act_e - c0, 1);
            if (size > 0) begin
                check_eq("act_to_pop", (first_s + 1) - act_e, 2);
                check_eq("pops_consecutive", last_s - first_s, size - 1);
                check_eq("last_pop_to_release", fall_e - (last_s + 1), 1);
            end else begin
                check_eq("act_width_size0", act_n, 3);
                check_eq("valid_size0", vld_n, 0);
            end
        end
        wait_drain();
    endtask

    task automatic push_tp_lines(input int mode, input logic [PW-1:0] color, input int lines);
        logic [PW-1:0] px;
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < HA; c++) begin
                case (mode)
                    1:       px = color;
                    2:       px = BARS[c / (HA / 8)];
                    default: px = {3{8'(c)}};
                endcase
                exp_q.push_back('{data: px, last: (c == HA - 1)});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int sz;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", o_pixel_valid, 0);
        check_eq("rst_act", o_read_act, 0);
        check_eq("rst_stb", o_read_stb, 0);
        check_eq("rst_data", o_pixel_data, 0);
        check_eq("rst_last", o_pixel_last, 0);
        rst = 1'b0;

        rdy_mode = 0;
        start_block(4, 1);
        finish_block(4, 1);
        rdy_mode = 1;
        start_block(4, 1);
        finish_block(4, 0);
        rdy_mode = 0;
        start_block(0, 0);
        finish_block(0, 1);

        for (int t = 0; t < 8; t++) begin
            rdy_mode = $urandom_range(0, 2);
`ifndef PIXEL_STREAM_READER_TP_EN
            i_tp_mode  = 2'($urandom_range(1, 3));
            i_tp_color = PW'($urandom);
`endif
            sz = $urandom_range(0, 12);
            start_block(sz, 0);
            finish_block(sz, 0);
        end
        i_tp_mode = 2'd0;

        // Reset with a held pixel mid-block.
        rdy_mode = 0;
        base     = pop_cnt;
        start_block(8, 0);
        for (int k = 0; k < 100 && pop_cnt - base < 2; k++) begin
            @(negedge clk);
            if (o_read_act) i_read_rdy = 1'b0;
        end
        rdy_mode = 3;
        check_eq("pops_before_rst", pop_cnt - base, 2);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_mid_valid", o_pixel_valid, 0);
        check_eq("rst_mid_act", o_read_act, 0);
        check_eq("rst_mid_stb", o_read_stb, 0);
        check_eq("rst_mid_last", o_pixel_last, 0);
        rst = 1'b0;
        exp_q.delete();
        i_read_rdy = 1'b0;
        blk_size   = 0;
        ptr        = 0;
        rdy_mode   = 2;
        start_block(5, 0);
        finish_block(5, 0);

`ifdef PIXEL_STREAM_READER_TP_EN
        @(posedge clk);
        #1;
        rdy_mode = 0;
        push_tp_lines(2, '0, 2);
        i_tp_mode = 2'd2;
        wait_q_le(8);
        i_tp_mode = 2'd0;
        wait_drain();
        repeat (3) @(negedge clk);
        check_eq("tp_bars_stopped", o_pixel_valid, 0);

        @(posedge clk);
        #1;
        rdy_mode = 2;
        push_tp_lines(3, '0, 2);
        i_tp_mode = 2'd3;
        wait_q_le(5);
        start_block(6, 0);
        i_tp_mode = 2'd0;
        finish_block(6, 0);

        @(posedge clk);
        #1;
        rdy_mode   = 1;
        i_tp_color = PW'($urandom);
        push_tp_lines(1, i_tp_color, 1);
        i_tp_mode = 2'd1;
        wait_q_le(10);
        i_tp_mode = 2'd0;
        wait_drain();
        repeat (4) @(negedge clk);
        check_eq("tp_solid_stopped", o_pixel_valid, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_reader.md
# pixel_stream_reader

Parametrised pixel source between the video ping-pong FIFO read port and the TFT/video output timing engine. It claims a ready FIFO block and pops `i_read_size` words. Each word is presented as one pixel on a registered valid/ready stream with an end-of-block marker. An optional test-pattern generator (solid, colour bars, ramp) can replace FIFO data.

## Interface
- `CHAN_WIDTH`, 8, bits per colour channel.
- `NUM_CHAN`, 3, channels per pixel; channel 0 occupies the MSBs (red).
- `SIZE_WIDTH`, 24, width of the block size and pixel counter.
- `H_ACTIVE`, 480, pixels per line for test patterns; must be a multiple of 8.
- `PIX_W` (localparam) = `NUM_CHAN*CHAN_WIDTH`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_read_rdy` in 1: FIFO block available.
- `o_read_act` out 1: FIFO block claimed.
- `i_read_size` in `SIZE_WIDTH`: words in the claimed block.
- `i_read_data` in `PIX_W`: current FIFO word, first-word-fall-through.
- `o_read_stb` out 1: pop pulse for one word.
- `i_tp_mode` in 2: 0 = FIFO, 1 = solid, 2 = colour bars, 3 = ramp.
- `i_tp_color` in `PIX_W`: colour for solid mode.
- `o_pixel_data` out `PIX_W`: pixel.
- `o_pixel_valid` out 1: pixel valid.
- `i_pixel_ready` in 1: downstream accepts pixel.
- `o_pixel_last` out 1: last pixel of a FIFO block, or last pixel of a test-pattern line.

## Operation
- FSM states: IDLE, CLAIM, STREAM, RELEASE, TP.
- IDLE:
  - Mode is sampled only in IDLE.
  - `i_tp_mode`≠0 → TP.
  - Otherwise, `i_read_rdy` → CLAIM, `o_read_act`←1, counter←0.
- CLAIM: one cycle for `i_read_size` to settle; then STREAM.
- STREAM, load condition is `!o_pixel_valid || i_pixel_ready`:
  - If load holds and counter<size: pulse `o_read_stb`, register `i_read_data`, `o_pixel_valid`←1, counter+1.
  - `o_pixel_last`←1 when counter+1==size.
  - When counter==size → RELEASE.
- RELEASE: `o_read_act`←0, then IDLE.
  - The output register may still hold the final pixel; it drains independently.
- Size 0: CLAIM→STREAM→RELEASE with no pops.
- TP:
  - Generates a pixel every load cycle and advances column counter `col`, which wraps at `H_ACTIVE-1`; `o_pixel_last` is set at `col==H_ACTIVE-1`.
  - Solid outputs `i_tp_color`.
  - Bars: bar index = `col/(H_ACTIVE/8)`, order white, yellow, cyan, green, magenta, red, blue, black; each channel is all-ones or zero.
  - Ramp: every channel = `col[CHAN_WIDTH-1:0]`.
  - Returns to IDLE only at a line end (accepted last pixel) with `i_tp_mode`==0.
- Counter compare is unsigned `SIZE_WIDTH`-bit; no wrap, since the counter never exceeds size.
- `i_read_rdy` falling while claimed is ignored until RELEASE.

## Timing
- Reset values:
  - FSM = IDLE, `o_read_act`=0, `o_read_stb`=0.
  - `o_pixel_valid`=0, `o_pixel_last`=0, `o_pixel_data`=0, counter=0, `col`=0.
- Reset mid-block drops the held pixel and releases the FIFO in the same edge.
- Latency:
  - `i_read_rdy` → `o_read_act`: 1 cycle.
  - `o_read_act` → first `o_read_stb`: 2 cycles.
  - Pop → `o_pixel_valid`: same edge; data is registered on the pop cycle.
- Throughput: one pixel/cycle while `i_pixel_ready`=1.
- Valid/ready rules:
  - Data, valid and last hold stable while valid=1 and ready=0.
  - Valid drops the cycle after acceptance when no new load occurs.
- `o_read_stb` is never asserted when `o_read_act`=0 or counter==size.

## Configuration
- `PIXEL_STREAM_READER_TP_EN` defined: TP state and pattern logic are present as above.
- Undefined:
  - `i_tp_mode` and `i_tp_color` remain ports but are ignored.
  - The FSM never enters TP and `col` logic is absent.
  - Only FIFO data is output.

## Structure
- Package `pixel_stream_pkg`:
  - `tp_mode_t` enum (TP_OFF, TP_SOLID, TP_BARS, TP_RAMP).
  - FSM state enum.
  - The 8-entry bar colour LUT as a function of `CHAN_WIDTH`/`NUM_CHAN`.
- Sub-module `pixel_tp_gen`: combinational pattern from mode, col, colour; instantiated only under the macro.
- The FSM and output register live in the top module.

## Test plan
- Block size 4, data 0x112233..0x445566, ready=1 → 4 stb pulses on consecutive cycles and 4 pixels in order. Last on 0x445566. `o_read_act` falls 1 cycle after counter reaches 4.
- Same block, ready toggling 1010… → each pixel held stable while ready=0. No stb while valid&&!ready. Total stb = 4.
- Size 0 → `o_read_act` high exactly 3 cycles, zero stb, no valid.
- TP bars, `H_ACTIVE`=16, ready=1 → pixels 0–1 = 0xFFFFFF, 2–3 = 0xFFFF00, …, 14–15 = 0x000000. Last at pixel 15, repeating.
- TP ramp mode set to 0 mid-line → continues to col 15 (last), then IDLE, then claims a pending FIFO block.
- `rst` asserted after 2 of 8 pops with ready=0 → next cycle valid=0, act=0, stb=0. A new claim starts from counter 0.
